// File: rtl/case_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : case_reg_arbiter
// Brief    : Round-robin arbiter/sequencer sharing one registered DATA_W-bit
//            register among NUM_REQ requesters. The granted requester's 2-bit
//            opcode is case-decoded into hold / load / invert / clear.
//            Optional macro PARITY_EN adds a registered even-parity output
//            data_par that tracks data_out.
// Revision : 1.0 - initial release
// ============================================================================
module case_reg_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [2*NUM_REQ-1:0]       op,
  input  logic [DATA_W*NUM_REQ-1:0]  wdata,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       busy,
  output logic                       done,
  output logic [DATA_W-1:0]          data_out
`ifdef PARITY_EN
  , output logic                     data_par
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    EXEC = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [PTR_W-1:0]    rr_ptr, rr_ptr_n;
  logic [PTR_W-1:0]    win, win_n;
  logic [1:0]          op_lat, op_lat_n;
  logic [DATA_W-1:0]   wd_lat, wd_lat_n;
  logic [DATA_W-1:0]   data_n;
  logic [NUM_REQ-1:0]  gnt_n;
  logic                done_n;
  logic                busy_n;

  // Scan results: first asserted request at or after rr_ptr, wrapping.
  logic                found;
  logic [PTR_W-1:0]    scan_win;
  logic [PTR_W:0]      scan_sum;
  logic [PTR_W-1:0]    scan_idx;
  logic [1:0]          sel_op;
  logic [DATA_W-1:0]   sel_wd;
  logic [NUM_REQ-1:0]  scan_onehot;

  // Round-robin search by increasing distance from rr_ptr
  always_comb begin
    found    = 1'b0;
    scan_win = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
      end
      scan_idx = scan_sum[PTR_W-1:0];
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req[j] && (scan_idx == PTR_W'(j))) begin
          found    = 1'b1;
          scan_win = PTR_W'(j);
        end
      end
    end
  end

  // Select the winner's opcode, write data and one-hot grant
  always_comb begin
    sel_op      = 2'b00;
    sel_wd      = '0;
    scan_onehot = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (scan_win == PTR_W'(j)) begin
        sel_op         = op[2*j +: 2];
        sel_wd         = wdata[DATA_W*j +: DATA_W];
        scan_onehot[j] = 1'b1;
      end
    end
  end

  // Next-state and next-output decode; all outputs are registered below
  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    done_n   = 1'b0;
    data_n   = data_out;
    rr_ptr_n = rr_ptr;
    win_n    = win;
    op_lat_n = op_lat;
    wd_lat_n = wd_lat;
    case (state)
      IDLE: begin
        if (|req) state_n = ARB;
      end
      ARB: begin
        if (found) begin
          state_n  = EXEC;
          gnt_n    = scan_onehot;
          win_n    = scan_win;
          op_lat_n = sel_op;
          wd_lat_n = sel_wd;
        end else begin
          // Requester withdrew before arbitration: abandon quietly.
          state_n = IDLE;
          gnt_n   = '0;
        end
      end
      EXEC: begin
        case (op_lat)
          2'b00:   data_n = data_out;
          2'b01:   data_n = wd_lat;
          2'b10:   data_n = ~data_out;
          2'b11:   data_n = '0;
          default: data_n = data_out;
        endcase
        done_n  = 1'b1;
        state_n = ACK;
      end
      ACK: begin
        gnt_n    = '0;
        rr_ptr_n = (win == PTR_W'(NUM_REQ-1)) ? '0 : win + PTR_W'(1);
        state_n  = IDLE;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
      rr_ptr   <= '0;
      win      <= '0;
      op_lat   <= 2'b00;
      wd_lat   <= '0;
    end else begin
      gnt      <= gnt_n;
      busy     <= busy_n;
      done     <= done_n;
      data_out <= data_n;
      rr_ptr   <= rr_ptr_n;
      win      <= win_n;
      op_lat   <= op_lat_n;
      wd_lat   <= wd_lat_n;
    end
  end

`ifdef PARITY_EN
  // Even parity registered on the same edge as data_out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_par <= 1'b0;
    else     data_par <= ^data_n;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_case_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_case_reg_arbiter
// Brief    : Scoreboard bench for case_reg_arbiter. A driver issues directed
//            and random transactions and pushes the reference model's
//            expected grant/data; a monitor pops and compares on each done.
//            Honours PARITY_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_case_reg_arbiter;

  localparam int N  = 4;
  localparam int DW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [2*N-1:0]  op;
  logic [DW*N-1:0] wdata;
  logic [N-1:0]    gnt;
  logic            busy;
  logic            done;
  logic [DW-1:0]   data_out;
`ifdef PARITY_EN
  logic            data_par;
`endif

  case_reg_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .op       (op),
    .wdata    (wdata),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
`ifdef PARITY_EN
    , .data_par (data_par)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  gnt;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q[$];
  int            tests  = 0;
  int            errors = 0;
  int            m_ptr  = 0;
  logic [DW-1:0] m_data = '0;
  bit            prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: round-robin winner by distance from the pointer
  function automatic int model_winner(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] model_apply(input logic [DW-1:0] cur,
                                                input logic [1:0] o,
                                                input logic [DW-1:0] w);
    case (o)
      2'b01:   return w;
      2'b10:   return ~cur;
      2'b11:   return '0;
      default: return cur;
    endcase
  endfunction

  task automatic push_txn(input logic [N-1:0] r, input logic [2*N-1:0] o, input logic [DW*N-1:0] w);
    exp_t e;
    int   win;
    win    = model_winner(r, m_ptr);
    e.gnt  = '0;
    e.gnt[win] = 1'b1;
    m_data = model_apply(m_data, o[2*win +: 2], w[DW*win +: DW]);
    e.data = m_data;
    q.push_back(e);
    m_ptr  = (win + 1) % N;
  endtask

  // One transaction from IDLE; drops req in the cycle done is seen
  task automatic do_txn(input logic [N-1:0] r, input logic [2*N-1:0] o,
                        input logic [DW*N-1:0] w, input bit scramble);
    int cycles;
    @(negedge clk);
    req = r; op = o; wdata = w;
    push_txn(r, o, w);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (scramble && cycles == 2) begin
        op    = 8'($urandom);
        wdata = 8'($urandom);
      end
    end while (!done && cycles < 20);
    if (!done) begin
      tests++; errors++;
      $display("FAIL txn_timeout: got no done expected done within 20 cycles");
    end else begin
      check("latency", cycles, 3);
    end
    req = '0;
  endtask

  // Monitor: pop and compare whenever the DUT signals completion
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_done) begin
        check("done_one_cycle", {31'b0, done}, 0);
        check("busy_after_done", {31'b0, busy}, 0);
        check("gnt_after_done", {28'b0, gnt}, 0);
      end
      if (done) begin
        if (q.size() == 0) begin
          tests++; errors++;
          $display("FAIL unexpected_done: got done expected no transaction pending");
        end else begin
          exp_t e;
          e = q.pop_front();
          check("gnt", {28'b0, gnt}, {28'b0, e.gnt});
          check("data_out", {30'b0, data_out}, {30'b0, e.data});
          check("busy_in_ack", {31'b0, busy}, 1);
`ifdef PARITY_EN
          check("data_par", {31'b0, data_par}, {31'b0, ^e.data});
`endif
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    logic [2*N-1:0] bo;
    logic [DW*N-1:0] bw;

    rst = 1'b1; req = '0; op = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", {28'b0, gnt}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_data", {30'b0, data_out}, 0);
`ifdef PARITY_EN
    check("rst_par", {31'b0, data_par}, 0);
`endif
    rst = 1'b0;

    // Load 2'b10 from requester 1
    do_txn(4'b0010, 8'b0000_0100, 8'b0000_1000, 1'b0);
    // Requester 0: invert, clear, hold
    do_txn(4'b0001, 8'b0000_0010, 8'b0, 1'b0);
    do_txn(4'b0001, 8'b0000_0011, 8'b0, 1'b0);
    do_txn(4'b0001, 8'b0000_0000, 8'b0, 1'b0);
    // Parity-relevant loads: 2'b01 then 2'b11
    do_txn(4'b0001, 8'b0000_0001, 8'b0000_0001, 1'b0);
    do_txn(4'b0001, 8'b0000_0001, 8'b0000_0011, 1'b0);
    // Pointer to 3 via requester 2, then wrap 3 -> 0 with req=1001
    do_txn(4'b0100, 8'b0011_0000, 8'b0, 1'b0);
    do_txn(4'b1001, 8'b0100_0001, 8'b1100_0001, 1'b0);
    do_txn(4'b1001, 8'b0100_0001, 8'b1100_0001, 1'b0);

    // Random traffic with op/wdata scrambled after arbitration
    for (int t = 0; t < 40; t++) begin
      do_txn(4'($urandom_range(1, 15)), 8'($urandom), 8'($urandom), 1'b1);
    end

    // Reset during EXEC of a load of 2'b11
    @(negedge clk);
    req = 4'b0001; op = 8'b0000_0001; wdata = 8'b0000_0011;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (gnt == '0 && cycles < 10);
    check("exec_gnt", {28'b0, gnt}, 32'h1);
    rst = 1'b1;
    #1;
    check("abort_gnt", {28'b0, gnt}, 0);
    check("abort_done", {31'b0, done}, 0);
    check("abort_data", {30'b0, data_out}, 0);
    check("abort_busy", {31'b0, busy}, 0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    m_data = '0; m_ptr = 0;
    repeat (6) @(negedge clk);
    check("post_abort_data", {30'b0, data_out}, 0);
    check("post_abort_busy", {31'b0, busy}, 0);

    // Burst: all requests held for 16 back-to-back transactions
    bo = 8'($urandom); bw = 8'($urandom);
    @(negedge clk);
    req = 4'hF; op = bo; wdata = bw;
    for (int t = 0; t < 16; t++) push_txn(4'hF, bo, bw);
    for (int t = 0; t < 16; t++) begin
      cycles = 0;
      do begin
        @(negedge clk);
        cycles++;
      end while (!done && cycles < 30);
      if (!done) begin
        tests++; errors++;
        $display("FAIL burst_timeout: got no done expected done (txn %0d)", t);
      end else begin
        check("burst_spacing", cycles, (t == 0) ? 3 : 4);
      end
    end
    req = '0;

    repeat (6) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire
